// File: rtl/fbcpu_pkg.sv
// fbcpu_pkg: shared types and constants for the FBCPU memory responder.
// Holds the RAM state encoding, default widths, the instruction word layout
// and the opcode set used when building program images.
package fbcpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OPER_W = DATA_W - OPC_W;

  // Responder lifecycle: clear array, accept image, serve the CPU.
  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  typedef enum logic [OPC_W-1:0] {
    LOAD  = 4'd0,
    STORE = 4'd1,
    ADD   = 4'd2,
    SUB   = 4'd3,
    MUL   = 4'd4,
    DIV   = 4'd5,
    JMP   = 4'd6,
    JZ    = 4'd7,
    NOP   = 4'd8,
    HALT  = 4'd9
  } opcode_e;

  // Instruction word: opcode in the upper bits, operand in the lower bits.
  typedef struct packed {
    opcode_e             opcode;
    logic [OPER_W-1:0]   operand;
  } instr_t;

  // Pack an opcode/operand pair into a memory word.
  function automatic logic [DATA_W-1:0] make_instr(opcode_e op, logic [OPER_W-1:0] operand);
    instr_t w;
    w.opcode  = op;
    w.operand = operand;
    return DATA_W'(w);
  endfunction

endpackage

// File: rtl/fbcpu_ram_array.sv
// fbcpu_ram_array: DEPTH x DW single-write-port storage with a registered,
// read-first output. With FBCPU_RAM_PARITY_EN each word carries an extra
// even-parity bit generated on write and checked on the combinational read.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset (read register only)
//   we           write enable; waddr/wdata written at the edge
//   rd_en        1: rdata <= mem[raddr] at the edge; 0: rdata <= 0
//   rdata        registered read data (data bits only)
//   rerr_c       (parity build) parity mismatch on mem[raddr], combinational
module fbcpu_ram_array #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
`ifdef FBCPU_RAM_PARITY_EN
  ,
  output logic          rerr_c
`endif
);

  localparam int unsigned DEPTH = 32'(1) << AW;

`ifdef FBCPU_RAM_PARITY_EN
  localparam int unsigned WW = DW + 1;
`else
  localparam int unsigned WW = DW;
`endif

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] wword;
  logic [WW-1:0] rword;

`ifdef FBCPU_RAM_PARITY_EN
  // Stored parity bit makes the XOR of the whole word zero.
  assign wword  = {^wdata, wdata};
  assign rword  = mem[raddr];
  assign rerr_c = ^rword;
`else
  assign wword  = wdata;
  assign rword  = mem[raddr];
`endif

  // Storage has no reset; the owning FSM clears it after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wword;
    end
  end

  // Read register sees the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rword[DW-1:0];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/fbcpu_ram.sv
// fbcpu_ram: memory responder for the FBCPU core. After reset it zeroes the
// whole array, then accepts a program image over a valid/ready load port and
// finally serves the CPU MAR/MDRIn/RAMWr/MDROut port with 1-cycle read latency.
// cpu_run releases the CPU from reset upstream.
//
// Optional: define FBCPU_RAM_PARITY_EN for per-word even parity and a sticky
// parity_err output.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   MAR, RAMWr, MDRIn   CPU address, write strobe, write data
//   MDROut              registered CPU read data (0 outside S_RUN)
//   ld_valid/ld_ready   load beat handshake; ld_addr, ld_data, ld_last payload
//   cpu_run             high in S_RUN
//   clr_busy            high in S_CLEAR
//   parity_err          (parity build) sticky read parity error
module fbcpu_ram
  import fbcpu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH    = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [DATA_WIDTH-1:0]    MDROut,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     cpu_run,
  output logic                     clr_busy
`ifdef FBCPU_RAM_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  logic                     we_c;
  logic [ADDRESS_WIDTH-1:0] waddr_c;
  logic [DATA_WIDTH-1:0]    wdata_c;
  logic                     rd_en_c;

  // Next state and write-port mux: clear counter, load beat, or CPU write.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    we_c      = 1'b0;
    waddr_c   = MAR;
    wdata_c   = MDRIn;
    rd_en_c   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        we_c      = 1'b1;
        waddr_c   = clr_ptr_q;
        wdata_c   = '0;
        clr_ptr_d = clr_ptr_q + ADDRESS_WIDTH'(1);
        if (clr_ptr_q == {ADDRESS_WIDTH{1'b1}}) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        we_c    = ld_valid && ld_ready;
        waddr_c = ld_addr;
        wdata_c = ld_data;
        if (ld_valid && ld_ready && ld_last) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        we_c    = RAMWr;
        rd_en_c = 1'b1;
      end
      default: begin
        state_d   = S_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // State, clear pointer and status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      ld_ready  <= 1'b0;
      cpu_run   <= 1'b0;
      clr_busy  <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ready  <= (state_d == S_LOAD);
      cpu_run   <= (state_d == S_RUN);
      clr_busy  <= (state_d == S_CLEAR);
    end
  end

`ifdef FBCPU_RAM_PARITY_EN
  logic rerr_c;

  // Sticky error, sampled on the same edge that loads MDROut.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (rd_en_c && rerr_c) begin
      parity_err <= 1'b1;
    end
  end
`endif

  fbcpu_ram_array #(
    .AW (ADDRESS_WIDTH),
    .DW (DATA_WIDTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (we_c),
    .waddr  (waddr_c),
    .wdata  (wdata_c),
    .rd_en  (rd_en_c),
    .raddr  (MAR),
    .rdata  (MDROut)
`ifdef FBCPU_RAM_PARITY_EN
    ,
    .rerr_c (rerr_c)
`endif
  );

endmodule

// File: tb/tb_fbcpu_ram.sv
// tb_fbcpu_ram: self-checking bench for fbcpu_ram. A plain array model of the
// memory tracks clear, load and CPU writes; reads are predicted as the word
// held before any same-cycle write.
module tb_fbcpu_ram;
  import fbcpu_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] MAR;
  logic       RAMWr;
  logic [9:0] MDRIn;
  logic [9:0] MDROut;
  logic       ld_valid;
  logic       ld_ready;
  logic [5:0] ld_addr;
  logic [9:0] ld_data;
  logic       ld_last;
  logic       cpu_run;
  logic       clr_busy;
`ifdef FBCPU_RAM_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [9:0] model [64];

  fbcpu_ram dut (
    .clk      (clk),
    .rst      (rst),
    .MAR      (MAR),
    .RAMWr    (RAMWr),
    .MDRIn    (MDRIn),
    .MDROut   (MDROut),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .cpu_run  (cpu_run),
    .clr_busy (clr_busy)
`ifdef FBCPU_RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    MAR      = '0;
    RAMWr    = 1'b0;
    MDRIn    = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_last  = 1'b0;
  endtask

  // Count edges from reset release until clearing ends; the array is then all zero.
  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (clr_busy === 1'b1 && cnt < 200);
    checks++;
    if (cnt !== 64) begin errors++; $display("FAIL %s_clear_cycles: got %0d expected 64", tag, cnt); end
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL %s_ld_ready_after_clear: got %b expected 1", tag, ld_ready); end
    checks++;
    if (cpu_run !== 1'b0) begin errors++; $display("FAIL %s_cpu_run_after_clear: got %b expected 0", tag, cpu_run); end
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // One CPU cycle: drive at negedge, predict read-first, check after the edge.
  task automatic cpu_cycle(input logic [5:0] a, input logic w, input logic [9:0] d, input string tag);
    logic [9:0] exp;
    @(negedge clk);
    MAR = a; RAMWr = w; MDRIn = d;
    exp = model[a];
    @(posedge clk); #1;
    if (w) model[a] = d;
    checks++;
    if (MDROut !== exp) begin errors++; $display("FAIL %s_read[%0d]: got %h expected %h", tag, a, MDROut, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (MDROut !== 10'h000) begin errors++; $display("FAIL reset_mdrout: got %h expected 000", MDROut); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
    checks++;
    if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run: got %b expected 0", cpu_run); end
    checks++;
    if (clr_busy !== 1'b1) begin errors++; $display("FAIL reset_clr_busy: got %b expected 1", clr_busy); end
`ifdef FBCPU_RAM_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
  endtask

  task automatic test_clear();
    rst = 1'b1;
    wait_clear("first");
    checks++;
    if (MDROut !== 10'h000) begin errors++; $display("FAIL clear_mdrout: got %h expected 000", MDROut); end
  endtask

  // Image {0:005, 1:246, 5:007}; every other cycle is a stall carrying junk and ld_last.
  task automatic test_load_stall();
    logic [5:0] addrs [3];
    logic [9:0] datas [3];
    int beat;
    logic hs, last;
    addrs[0] = 6'd0; datas[0] = make_instr(LOAD, 6'd5);
    addrs[1] = 6'd1; datas[1] = make_instr(HALT, 6'd6);
    addrs[2] = 6'd5; datas[2] = make_instr(LOAD, 6'd7);
    beat = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      hs = cyc[0];
      if (hs) begin
        ld_valid = 1'b1; ld_addr = addrs[beat]; ld_data = datas[beat];
        ld_last = (beat == 2);
      end else begin
        ld_valid = 1'b0; ld_addr = 6'd2; ld_data = 10'h3AA; ld_last = 1'b1;
      end
      last = hs && (beat == 2);
      @(posedge clk); #1;
      if (hs) begin
        model[addrs[beat]] = datas[beat];
        beat++;
      end
      checks++;
      if (cpu_run !== last) begin errors++; $display("FAIL load_cpu_run_cyc%0d: got %b expected %b", cyc, cpu_run, last); end
      checks++;
      if (MDROut !== 10'h000) begin errors++; $display("FAIL load_mdrout_cyc%0d: got %h expected 000", cyc, MDROut); end
    end
    idle_inputs();
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    MAR = 6'd1;
    @(posedge clk); #1;
    checks++;
    if (MDROut !== 10'h246) begin errors++; $display("FAIL latency_mar1: got %h expected 246", MDROut); end
    for (int a = 0; a < 64; a++) cpu_cycle(6'(a), 1'b0, 10'h0, "sweep");
  endtask

  task automatic test_write_read();
    @(negedge clk);
    MAR = 6'd9; RAMWr = 1'b1; MDRIn = 10'h3FF;
    @(posedge clk); #1;
    checks++;
    if (MDROut !== 10'h000) begin errors++; $display("FAIL wr_same_cycle: got %h expected 000", MDROut); end
    @(negedge clk);
    RAMWr = 1'b0; MDRIn = 10'h0;
    @(posedge clk); #1;
    checks++;
    if (MDROut !== 10'h3FF) begin errors++; $display("FAIL wr_next_cycle: got %h expected 3ff", MDROut); end
    model[9] = 10'h3FF;
  endtask

  task automatic test_load_isolation();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MAR = 6'd3; ld_valid = 1'b1; ld_addr = 6'd0; ld_data = 10'h111; ld_last = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ld_ready !== 1'b0) begin errors++; $display("FAIL iso_ld_ready_%0d: got %b expected 0", i, ld_ready); end
      checks++;
      if (cpu_run !== 1'b1) begin errors++; $display("FAIL iso_cpu_run_%0d: got %b expected 1", i, cpu_run); end
    end
    idle_inputs();
    cpu_cycle(6'd0, 1'b0, 10'h0, "iso");
    checks++;
    if (MDROut !== 10'h005) begin errors++; $display("FAIL iso_mem0: got %h expected 005", MDROut); end
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 400; i++) begin
      ld_valid = 1'($urandom);
      ld_addr  = 6'($urandom);
      ld_data  = 10'($urandom);
      cpu_cycle(6'($urandom_range(0, 63)), 1'($urandom), 10'($urandom), "rand");
      checks++;
      if (ld_ready !== 1'b0) begin errors++; $display("FAIL rand_ld_ready_%0d: got %b expected 0", i, ld_ready); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_clear("mid1");
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 6'(10 + b); ld_data = 10'h155 + 10'(b); ld_last = 1'b0;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (clr_busy !== 1'b1) begin errors++; $display("FAIL mid_async_clr_busy: got %b expected 1", clr_busy); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL mid_async_ld_ready: got %b expected 0", ld_ready); end
    @(negedge clk);
    rst = 1'b1;
    wait_clear("mid2");
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 6'd63; ld_data = make_instr(JMP, 6'd1); ld_last = 1'b1;
    @(posedge clk); #1;
    model[63] = make_instr(JMP, 6'd1);
    idle_inputs();
    checks++;
    if (cpu_run !== 1'b1) begin errors++; $display("FAIL mid_cpu_run: got %b expected 1", cpu_run); end
    cpu_cycle(6'd10, 1'b0, 10'h0, "mid");
    cpu_cycle(6'd11, 1'b0, 10'h0, "mid");
    cpu_cycle(6'd63, 1'b0, 10'h0, "mid");
    cpu_cycle(6'd0,  1'b0, 10'h0, "mid");
    cpu_cycle(6'd1,  1'b0, 10'h0, "mid");
  endtask

`ifdef FBCPU_RAM_PARITY_EN
  task automatic test_parity();
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean: got %b expected 0", parity_err); end
    @(negedge clk);
    dut.u_array.mem[5][0] = ~dut.u_array.mem[5][0];
    model[5] = model[5] ^ 10'h001;
    cpu_cycle(6'd5, 1'b0, 10'h0, "par");
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_set: got %b expected 1", parity_err); end
    cpu_cycle(6'd0, 1'b0, 10'h0, "par");
    cpu_cycle(6'd1, 1'b0, 10'h0, "par");
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_sticky: got %b expected 1", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_load_stall();
    test_read_latency();
    test_write_read();
    test_load_isolation();
    test_random_run();
    test_reset_mid_load();
`ifdef FBCPU_RAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fbcpu_ram.md
Name: fbcpu_ram

Overview:
- Memory responder for the FBCPU core's MAR/MDRIn/RAMWr/MDROut interface.
- Holds 2^ADDRESS_WIDTH words of DATA_WIDTH bits with a synchronous read and a synchronous write.
- Clears its own array after reset, then accepts a program image over a valid/ready load port.
- Raises cpu_run once loading is finished; that signal releases the CPU's reset upstream.

Parameters:
- ADDRESS_WIDTH, 6, address bits; DEPTH = 2^ADDRESS_WIDTH words.
- DATA_WIDTH, 10, word width; upper 4 bits are opcode, lower 6 bits are operand.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- MAR  in  ADDRESS_WIDTH  CPU address, sampled at clk edge.
- RAMWr  in  1  CPU write strobe, sampled at clk edge.
- MDRIn  in  DATA_WIDTH  CPU write data.
- MDROut  out  DATA_WIDTH  registered read data.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted this cycle when ld_valid & ld_ready.
- ld_addr  in  ADDRESS_WIDTH  load beat address.
- ld_data  in  DATA_WIDTH  load beat data.
- ld_last  in  1  final beat of the image.
- cpu_run  out  1  high in S_RUN only.
- clr_busy  out  1  high in S_CLEAR only.

Behaviour:
- Reset (rst=0, async):
  - state=S_CLEAR, clr_ptr=0, MDROut=0, ld_ready=0, cpu_run=0, clr_busy=1.
  - Array contents are not touched asynchronously.
- S_CLEAR:
  - Each cycle: mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1, the last word is written and the next state is S_LOAD. Exactly DEPTH cycles are spent here.
  - CPU port and load port are ignored; MDROut is held at 0.
- S_LOAD:
  - ld_ready=1.
  - On a handshake: mem[ld_addr]<=ld_data at that edge. The data is readable from the next cycle.
  - A handshake with ld_last=1 moves to S_RUN at the same edge. ld_last without ld_valid is ignored.
  - Zero-beat images are not supported; at least one beat must carry ld_last.
  - CPU port is ignored; MDROut is held at 0.
- S_RUN:
  - ld_ready=0; ld_valid is ignored.
  - Every edge: MDROut<=mem[MAR]. This gives 1-cycle read latency, matching the CPU fetch (MAR driven in one state, MDROut consumed in the next).
  - RAMWr=1: mem[MAR]<=MDRIn at the edge.
  - Read and write to the same address in the same cycle is read-first: MDROut returns the old word.
  - S_RUN is left only by reset.
- Address wrap: none needed. Every ADDRESS_WIDTH value is a legal index, and clr_ptr wraps naturally at DEPTH-1.
- Reset mid-clear or mid-load restarts at S_CLEAR with clr_ptr=0; partially loaded words are overwritten by the clear.
- All outputs are registered, or decoded from the state register only.

Optional Feature:
- Macro: FBCPU_RAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed on every write (clear, load and CPU).
  - In S_RUN, a parity mismatch on the read word sets sticky output parity_err (1 bit) at the same edge MDROut updates.
  - parity_err is cleared only by reset.
- When undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Package fbcpu_pkg holds:
  - state encoding: S_CLEAR=2'd0, S_LOAD=2'd1, S_RUN=2'd2;
  - default widths ADDR_W=6, DATA_W=10;
  - opcode constants (LOAD=0, STORE=1, ADD=2, SUB=3, MUL=4, DIV=5, JMP=6, JZ=7, NOP=8, HALT=9), used by the bench image builder.
- One sub-module, fbcpu_ram_array: a DEPTH x DATA_WIDTH (+1 with parity) single-write-port array with registered read. The top holds the FSM, clear counter and write-port mux.

Test Plan:
- Reset release, clear: assert rst=0 then release → clr_busy=1 for exactly 64 cycles, then ld_ready=1; a later read of any address in S_RUN returns 0.
- Load stall: image {0:0x005, 1:0x246, 5:0x007}, ld_valid deasserted on alternate cycles → writes occur only on handshake cycles; ld_last on addr 5 → cpu_run=1 on the next cycle.
- Read latency: in S_RUN, MAR=1 at edge N → MDROut=0x246 after edge N, i.e. valid in cycle N+1.
- Write then read: RAMWr=1, MAR=9, MDRIn=0x3FF; same-cycle read returns the old value 0; MAR=9 one cycle later returns 0x3FF.
- Load-port isolation: ld_valid=1, ld_addr=0, ld_data=0x111 during S_RUN → ld_ready=0 and mem[0] stays 0x005.
- Reset mid-load: rst=0 after 2 beats → S_CLEAR restarts, loaded words read back as 0 after the next load of a 1-beat image to addr 63. With FBCPU_RAM_PARITY_EN, force-flip a stored bit → parity_err=1 and it stays high.
